// File: rtl/cpu_board_pkg.sv
// rtl/cpu_board_pkg.sv - shared state encoding and LED-to-RGB channel mapping
package cpu_board_pkg;

  // Encoding is visible on the status port, so the values are fixed.
  typedef enum logic [1:0] {
    ST_HOLD  = 2'b00,
    ST_RUN   = 2'b01,
    ST_HALT  = 2'b10,
    ST_STALL = 2'b11
  } state_t;

  // Bit positions in the RGB vector, numbered as the RGB driver pins.
  localparam int RGB_CH_GREEN = 0;
  localparam int RGB_CH_BLUE  = 1;
  localparam int RGB_CH_RED   = 2;

  // Which channels light up in each state; lit is the PWM phase,
  // act the retire activity bit, blink the slow blink phase.
  function automatic logic [2:0] led_rgb(input state_t st, input logic lit,
                                         input logic act, input logic blink);
    logic [2:0] rgb;
    rgb = '0;
    case (st)
      ST_HOLD:  rgb[RGB_CH_RED] = lit;
      ST_RUN: begin
        rgb[RGB_CH_RED]   = lit;
        rgb[RGB_CH_GREEN] = lit & act;
      end
      ST_HALT:  rgb[RGB_CH_BLUE] = lit;
      ST_STALL: rgb[RGB_CH_RED] = lit & blink;
      default:  rgb = '0;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// rtl/led_pwm_gen.sv - free-running brightness PWM counter and blink phase
module led_pwm_gen #(
  parameter int PWM_BITS   = 8,
  parameter int BLINK_BITS = 22
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                blink
);

  // Power-up values match the reset values so the board self-starts.
  logic [PWM_BITS-1:0]   pwm_q   = '0;
  logic [BLINK_BITS-1:0] blink_q = '0;

  // Both counters free-run and wrap; blink is the slow counter's MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_q   <= '0;
      blink_q <= '0;
    end else begin
      pwm_q   <= pwm_q + 1'b1;
      blink_q <= blink_q + 1'b1;
    end
  end

  assign pwm_cnt = pwm_q;
  assign blink   = blink_q[BLINK_BITS-1];

endmodule

// File: rtl/status_led_ctrl.sv
// rtl/status_led_ctrl.sv - CPU reset sequencer with halt/stall detection and RGB status LED
module status_led_ctrl
  import cpu_board_pkg::*;
#(
  parameter logic [23:0] RESET_CYCLES = 24'hFFFFFF,
  parameter logic [31:0] HALT_PC      = 32'h00000010,
  parameter int          STALL_CYCLES = 1000000,
  parameter int          PWM_BITS     = 8,
  parameter int unsigned BRIGHT       = 32'h20,
  parameter int          BLINK_BITS   = 22,
  parameter int          ACT_BIT      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_pc,
  input  logic        cpu_reg_wr,
  output logic        cpu_reset,
  output logic        pwm_red,
  output logic        pwm_green,
  output logic        pwm_blue,
  output logic [1:0]  status,
  output logic        halted
);

  localparam int              SW         = $clog2(STALL_CYCLES + 1);
  localparam logic [SW-1:0]   STALL_LAST = SW'(STALL_CYCLES - 1);

  // Power-up values equal the reset values so reset may be tied low.
  state_t        state       = ST_HOLD;
  logic [23:0]   hold_cnt    = RESET_CYCLES;
  logic          cpu_reset_q = 1'b1;
  logic [31:0]   pc_prev     = '0;
  logic [SW-1:0] stall_cnt   = '0;
  logic [15:0]   retire_cnt  = '0;
  logic [2:0]    led_q       = '0;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                blink;
  logic                lit;

  led_pwm_gen #(
    .PWM_BITS   (PWM_BITS),
    .BLINK_BITS (BLINK_BITS)
  ) u_pwm_gen (
    .clk     (clk),
    .reset   (reset),
    .pwm_cnt (pwm_cnt),
    .blink   (blink)
  );

  assign lit = (32'(pwm_cnt) < BRIGHT);

  // Main FSM: hold the CPU in reset, then watch for halt or a stuck PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_HOLD;
      hold_cnt    <= RESET_CYCLES;
      cpu_reset_q <= 1'b1;
    end else begin
      case (state)
        ST_HOLD: begin
          if (hold_cnt == '0) begin
            state       <= ST_RUN;
            cpu_reset_q <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        ST_RUN: begin
          // Halt is tested first so it wins over a simultaneous stall.
          if (cpu_pc == HALT_PC)
            state <= ST_HALT;
          else if (stall_cnt == STALL_LAST)
            state <= ST_STALL;
        end
        default: state <= state;
      endcase
    end
  end

  // Count consecutive RUN cycles with an unchanged PC, saturating at the trip value.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_prev   <= '0;
      stall_cnt <= '0;
    end else begin
      pc_prev <= cpu_pc;
      if (state != ST_RUN || cpu_pc != pc_prev)
        stall_cnt <= '0;
      else if (stall_cnt != STALL_LAST)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Retired register writes while running; one bit of it drives the activity LED.
  always_ff @(posedge clk) begin
    if (reset)
      retire_cnt <= '0;
    else if (state == ST_RUN && cpu_reg_wr)
      retire_cnt <= retire_cnt + 1'b1;
  end

  // Registered LED pins, one cycle behind state and counters.
  always_ff @(posedge clk) begin
    if (reset)
      led_q <= '0;
    else
      led_q <= led_rgb(state, lit, retire_cnt[ACT_BIT], blink);
  end

  assign cpu_reset = cpu_reset_q;
  assign status    = state;
  assign halted    = (state == ST_HALT);
  assign pwm_red   = led_q[RGB_CH_RED];
  assign pwm_green = led_q[RGB_CH_GREEN];
  assign pwm_blue  = led_q[RGB_CH_BLUE];

endmodule

// File: tb/tb_status_led_ctrl.sv
// tb/tb_status_led_ctrl.sv - directed bench for status_led_ctrl
module tb_status_led_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cpu_pc = '0;
  logic        cpu_reg_wr = 1'b0;
  logic        cpu_reset;
  logic        pwm_red, pwm_green, pwm_blue;
  logic [1:0]  status;
  logic        halted;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int hi_cnt = 0;
  logic [31:0] pc_run = '0;

  typedef struct {
    logic [31:0] pc;
    logic        wr;
    logic [1:0]  exp_status;
    logic        exp_halted;
  } vec_t;

  vec_t vecs [12];

  status_led_ctrl #(
    .RESET_CYCLES (24'd10),
    .HALT_PC      (32'h10),
    .STALL_CYCLES (8),
    .PWM_BITS     (4),
    .BRIGHT       (4),
    .BLINK_BITS   (5),
    .ACT_BIT      (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_pc     (cpu_pc),
    .cpu_reg_wr (cpu_reg_wr),
    .cpu_reset  (cpu_reset),
    .pwm_red    (pwm_red),
    .pwm_green  (pwm_green),
    .pwm_blue   (pwm_blue),
    .status     (status),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [31:0] pc, input logic wr);
    cpu_pc     = pc;
    cpu_reg_wr = wr;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // n = edges since reset release; the LED pin shows the counters from before edge n.
  function automatic logic lit_at(input int n);
    return ((n - 1) % 16) < 4;
  endfunction

  function automatic logic blink_at(input int n);
    return ((n - 1) % 32) >= 16;
  endfunction

  task automatic apply_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) step(cpu_pc, 1'b0);
    check("rst_status", status, 2'b00);
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_pwm", {pwm_red, pwm_green, pwm_blue}, 3'b000);
    check("rst_halted", halted, 1'b0);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic hold_phase(input logic [31:0] pc, input logic wr);
    check("hold_cpu_reset_first", cpu_reset, 1'b1);
    for (int n = 1; n <= 11; n++) begin
      step(pc, wr);
      check("hold_cpu_reset", cpu_reset, (n <= 10) ? 1'b1 : 1'b0);
      check("hold_status", status, (n <= 10) ? 2'b00 : 2'b01);
      check("hold_red", pwm_red, lit_at(n));
      check("hold_green_blue", {pwm_green, pwm_blue}, 2'b00);
    end
  endtask

  initial begin
    vecs[0]  = '{32'h00, 1'b0, 2'b01, 1'b0};
    vecs[1]  = '{32'h04, 1'b0, 2'b01, 1'b0};
    vecs[2]  = '{32'h08, 1'b0, 2'b01, 1'b0};
    vecs[3]  = '{32'h0C, 1'b0, 2'b01, 1'b0};
    vecs[4]  = '{32'h10, 1'b0, 2'b10, 1'b1};
    vecs[5]  = '{32'h20, 1'b0, 2'b10, 1'b1};
    vecs[6]  = '{32'h08, 1'b1, 2'b10, 1'b1};
    vecs[7]  = '{32'h08, 1'b0, 2'b10, 1'b1};
    vecs[8]  = '{32'h08, 1'b0, 2'b10, 1'b1};
    vecs[9]  = '{32'h08, 1'b0, 2'b10, 1'b1};
    vecs[10] = '{32'h08, 1'b0, 2'b10, 1'b1};
    vecs[11] = '{32'h08, 1'b0, 2'b10, 1'b1};

    // Power-on hold, then step to the halt PC.
    apply_reset(3);
    hold_phase(32'h0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].pc, vecs[i].wr);
      check("tbl_status", status, vecs[i].exp_status);
      check("tbl_halted", halted, vecs[i].exp_halted);
      check("tbl_cpu_reset", cpu_reset, 1'b0);
    end

    // Halted: blue at 4/16 duty, red and green dark.
    hi_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(32'h20, 1'b0);
      check("halt_blue", pwm_blue, lit_at(cyc));
      check("halt_red_green", {pwm_red, pwm_green}, 2'b00);
      hi_cnt += int'(pwm_blue);
    end
    check("halt_blue_duty", hi_cnt, 4);

    // Reset while halted repeats the whole hold.
    apply_reset(1);
    hold_phase(32'h0, 1'b0);

    // PC stuck at 0x8 trips the stall after 8 cycles.
    step(32'h4, 1'b0);
    for (int j = 0; j <= 8; j++) begin
      step(32'h8, 1'b0);
      check("stall_status", status, (j == 8) ? 2'b11 : 2'b01);
      check("stall_halted", halted, 1'b0);
    end
    hi_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      step(32'h8, 1'b0);
      check("stall_red", pwm_red, lit_at(cyc) & blink_at(cyc));
      check("stall_green_blue", {pwm_green, pwm_blue}, 2'b00);
      check("stall_sticky", status, 2'b11);
      check("stall_cpu_reset", cpu_reset, 1'b0);
      hi_cnt += int'(pwm_red);
    end
    check("stall_red_count", hi_cnt, 8);

    // PC parked at the halt address: halt wins, never stall.
    apply_reset(2);
    hold_phase(32'h10, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(32'h10, 1'b0);
      check("halt_wins_status", status, 2'b10);
      check("halt_wins_halted", halted, 1'b1);
    end

    // Writes during HOLD are ignored; two in RUN light green, two more clear it.
    apply_reset(2);
    hold_phase(32'h100, 1'b1);
    pc_run = 32'h104;
    for (int i = 0; i < 2; i++) begin
      step(pc_run, 1'b1);
      pc_run += 4;
    end
    hi_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(pc_run, 1'b0);
      pc_run += 4;
      check("act_green_on", pwm_green, lit_at(cyc));
      check("act_red", pwm_red, lit_at(cyc));
      check("act_status", status, 2'b01);
      hi_cnt += int'(pwm_green);
    end
    check("act_green_duty", hi_cnt, 4);
    for (int i = 0; i < 2; i++) begin
      step(pc_run, 1'b1);
      pc_run += 4;
    end
    for (int i = 0; i < 16; i++) begin
      step(pc_run, 1'b0);
      pc_run += 4;
      check("act_green_off", pwm_green, 1'b0);
      check("act_red_off_phase", pwm_red, lit_at(cyc));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
